matrix_key_scan: RTL
====================

// Module: matrix_key_scan
// PURPOSE
//  Reads a 4x4 active-low matrix keypad: drives columns, senses rows, debounces, and
//  reports one 4-bit key code per press as a single-cycle strobe. It is the input-side
//  counterpart of the scoreboard's multiplexed 7-seg scanner, and its codes feed score
//  and timer setting logic. One clock domain; row inputs are asynchronous pad signals.
// PARAMETERS
//  DEB_CYCLES   20'd500000  press/release stable time in clk cycles (10 ms @ 50 MHz); >=2
//  SETTLE       8'd64       cycles each column is driven before rows are sampled; >=3
// PORTS
//  clk        in   1  system clock
//  rst_n      in   1  asynchronous reset, active low
//  key_row    in   4  row sense lines, pulled up; 0 = connected to a driven column
//  key_col    out  4  column drive lines, active low
//  key_valid  out  1  one-cycle strobe: key_code is new
//  key_code   out  4  code of last accepted key = row_idx*4 + col_idx
//  key_held   out  1  1 from key_valid until release is debounced
// BEHAVIOUR
//  - key_row passes through a 2-flop synchronizer (row_s) before any use.
//  - Reset values: key_col=4'b0000, key_valid=0, key_code=4'h0, key_held=0, state=IDLE,
//    all counters 0. Reset mid-scan aborts immediately. No strobe is emitted on exit.
//  - States:
//    IDLE: key_col=0000. If row_s!=1111, go to PRESS_DEB with cnt=0.
//    PRESS_DEB: key_col=0000. If row_s==1111, go to IDLE. Otherwise cnt++. When
//      cnt==DEB_CYCLES-1, go to SCAN with col_idx=0 and cnt=0.
//    SCAN: key_col = ~(4'b0001<<col_idx). cnt counts 0..SETTLE-1. At cnt==SETTLE-1,
//      sample row_s:
//      - Any bit 0: latch the lowest-index 0 row as row_idx, go to REPORT.
//      - Otherwise, if col_idx==3, go to IDLE (bounce, no strobe).
//      - Otherwise, col_idx++ and cnt=0.
//    REPORT (1 cycle): key_valid=1, key_code={row_idx,col_idx}, key_held=1.
//      key_col=0000. Go to REL_DEB with cnt=0.
//    REL_DEB: key_col=0000. If row_s!=1111, cnt=0. Otherwise cnt++. When
//      cnt==DEB_CYCLES-1, key_held=0 and go to IDLE.
//  - Priority on multiple keys: lowest column wins, then lowest row within that column.
//    Extra keys pressed while held are ignored until all keys are released.
//  - key_code holds its value until the next REPORT. key_valid is 0 outside REPORT.
//  - Latency from a stable row edge at the pin to key_valid:
//    2 (sync) + 1 + DEB_CYCLES + (col_idx+1)*SETTLE + 1 cycles.
//  - Counters are sized for DEB_CYCLES and saturate-free: they are always cleared
//    before their terminal count is exceeded.
// TESTING  (sim with DEB_CYCLES=16, SETTLE=4; keypad model ties row r to col c when
//  key (r,c) is pressed; rows are pulled up)
//  1 Reset: assert rst_n=0 mid-SCAN -> key_col=0000, key_valid=0, key_held=0
//    immediately; after release, state IDLE.
//  2 Clean press of key (2,1), held 100 cycles -> exactly one key_valid, key_code=4'h9,
//    key_held=1. Release -> key_held=0 after 16 quiet cycles.
//  3 Bounce: row toggles every 5 cycles for 40 cycles, then stays low on key (0,3)
//    -> no strobe during bouncing, then one strobe with key_code=4'h3.
//  4 Glitch: row low for 6 cycles (< DEB_CYCLES) -> no key_valid; back in IDLE.
//  5 Two keys (1,2) and (3,0) pressed together -> key_code=4'hC, single strobe.
//    Releasing only (3,0) gives no new strobe.
//  6 Repeat: press/release key (0,0) three times -> three strobes with key_code=4'h0.
//    Each strobe waits for the release debounce of the previous press.

Source files
------------

// File: rtl/matrix_key_scan.sv
// matrix_key_scan: 4x4 active-low keypad scanner with press/release debounce.
// Emits one key_code strobe per debounced press, holds key_held until release.
module matrix_key_scan #(
    parameter logic [19:0] DEB_CYCLES = 20'd500000,
    parameter logic [7:0]  SETTLE     = 8'd64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_row,
    output logic [3:0] key_col,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held
);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_DEB,
        SCAN,
        REPORT,
        REL_DEB
    } state_t;

    state_t      state;
    logic [3:0]  row_m;
    logic [3:0]  row_s;
    logic [19:0] cnt;
    logic [1:0]  col_idx;
    logic [1:0]  low_row;
    logic        any_low;
    logic [19:0] deb_last;
    logic [19:0] settle_last;

    assign deb_last    = DEB_CYCLES - 20'd1;
    assign settle_last = {12'd0, SETTLE} - 20'd1;
    assign any_low     = (row_s != 4'hF);

    // Two-flop synchronizer; idles at "no key" so reset cannot fake a press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_m <= 4'hF;
            row_s <= 4'hF;
        end else begin
            row_m <= key_row;
            row_s <= row_m;
        end
    end

    // Lowest-index row that is pulled low wins within a column
    always_comb begin
        low_row = 2'd3;
        if (!row_s[0])      low_row = 2'd0;
        else if (!row_s[1]) low_row = 2'd1;
        else if (!row_s[2]) low_row = 2'd2;
    end

    // Scan/debounce controller with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 20'd0;
            col_idx   <= 2'd0;
            key_col   <= 4'b0000;
            key_valid <= 1'b0;
            key_code  <= 4'h0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            case (state)
                IDLE: begin
                    key_col <= 4'b0000;
                    if (any_low) begin
                        state <= PRESS_DEB;
                        cnt   <= 20'd0;
                    end
                end
                PRESS_DEB: begin
                    if (!any_low) begin
                        state <= IDLE;
                        cnt   <= 20'd0;
                    end else if (cnt == deb_last) begin
                        state   <= SCAN;
                        cnt     <= 20'd0;
                        col_idx <= 2'd0;
                        key_col <= 4'b1110;
                    end else begin
                        cnt <= cnt + 20'd1;
                    end
                end
                SCAN: begin
                    if (cnt == settle_last) begin
                        cnt <= 20'd0;
                        if (any_low) begin
                            state     <= REPORT;
                            key_valid <= 1'b1;
                            key_code  <= {low_row, col_idx};
                            key_held  <= 1'b1;
                            key_col   <= 4'b0000;
                        end else if (col_idx == 2'd3) begin
                            state   <= IDLE;
                            key_col <= 4'b0000;
                        end else begin
                            col_idx <= col_idx + 2'd1;
                            key_col <= ~(4'b0001 << (col_idx + 2'd1));
                        end
                    end else begin
                        cnt <= cnt + 20'd1;
                    end
                end
                REPORT: begin
                    state <= REL_DEB;
                    cnt   <= 20'd0;
                end
                REL_DEB: begin
                    if (any_low) begin
                        cnt <= 20'd0;
                    end else if (cnt == deb_last) begin
                        state    <= IDLE;
                        cnt      <= 20'd0;
                        key_held <= 1'b0;
                    end else begin
                        cnt <= cnt + 20'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= 20'd0;
                    key_col <= 4'b0000;
                end
            endcase
        end
    end

endmodule
